sm_ptr_alloc: RTL and testbench
===============================

Name: sm_ptr_alloc

Overview:
Free-pointer allocator for the shared-memory buffer. It sits directly upstream of the write path. Each allocate request returns a result record made of a result code (WR_OK or WR_ERR_NO_SPACE) and a pointer. FREE commands from the read/free path hand pointers back. Internally it holds a circular free-list FIFO of pointers plus an allocated-pointer bitmap that rejects double frees.

Parameters:
PTR_W, 8 (equals sm::SM_PTR_W), pointer width.
PTR_CNT, 2**PTR_W, number of buffer slots and free-list depth.

Ports:
clk_i  in  1  clock.
rst_n_i  in  1  reset, asynchronous, active-low.
init_done_o  out  1  high once the free list is fully populated.
alloc_req_i  in  1  allocate request.
alloc_ready_o  out  1  allocator accepts a request this cycle.
res_valid_o  out  1  result valid, single-cycle pulse.
res_o  out  sm_res_t  result record: code plus ptr.
free_valid_i  in  1  free request.
free_ptr_i  in  PTR_W  pointer being returned.
free_ready_o  out  1  allocator accepts a free this cycle.
err_double_free_o  out  1  pulse: freed pointer was not allocated.
free_cnt_o  out  PTR_W+1  number of pointers currently in the free list.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values:
  - state = INIT; rd_idx = wr_idx = 0; free_cnt_o = 0.
  - bitmap all 0; init_done_o = 0.
  - res_valid_o = 0; res_o = {WR_OK, 0}.
  - err_double_free_o = 0; alloc_ready_o = free_ready_o = 0.
- State machine has two states, INIT and RUN.
- INIT:
  - Each cycle, write value wr_idx into the FIFO RAM at wr_idx, then increment wr_idx and free_cnt.
  - After the write of PTR_CNT-1 the next state is RUN. wr_idx wraps to 0 and free_cnt = PTR_CNT.
  - INIT lasts exactly PTR_CNT cycles after reset release.
  - alloc_ready_o and free_ready_o stay 0 throughout. Requests presented are not accepted and have no effect.
- RUN:
  - init_done_o, alloc_ready_o and free_ready_o are 1 (registered).
  - RUN is only left by reset.
- Alloc accept = alloc_req_i & alloc_ready_o. Latency is 1: res_valid_o = 1 in the following cycle.
  - If free_cnt > 0 before this cycle's free: code WR_OK, ptr = FIFO[rd_idx]. Then rd_idx++ (wraps mod PTR_CNT), free_cnt--, bitmap[ptr] set.
  - Otherwise: code WR_ERR_NO_SPACE, ptr = 0, no state change.
  - Back-to-back accepts every cycle are supported.
- Free accept = free_valid_i & free_ready_o.
  - If bitmap[free_ptr_i] = 1: write ptr to FIFO[wr_idx], wr_idx++ (wraps), free_cnt++, bitmap bit cleared.
  - Else: ignored; err_double_free_o pulses 1 in the next cycle.
- Simultaneous alloc and free:
  - The alloc sees free_cnt before the free; there is no bypass. At free_cnt = 0 the alloc returns NO_SPACE and the free still lands, giving free_cnt = 1.
  - If both succeed, free_cnt is unchanged.
  - Freeing the pointer being allocated in the same cycle is a double-free error, because its bitmap bit is not yet set.
- free_cnt never exceeds PTR_CNT; the bitmap check guarantees this. The FIFO therefore cannot overflow.
- res_o holds its last value while res_valid_o = 0.
- Reset mid-operation clears everything and restarts INIT. Outstanding results are lost.

Test Plan:
1. Release reset, count cycles -> init_done_o rises exactly 256 cycles after rst_n_i goes high; free_cnt_o = 256; no accepts during INIT.
2. Three back-to-back allocs after init -> res_o = {WR_OK,0}, {WR_OK,1}, {WR_OK,2} on consecutive cycles, each 1 cycle after request; free_cnt_o = 253.
3. 257 allocs -> first 256 return WR_OK with ptrs 0..255; 257th returns {WR_ERR_NO_SPACE, 0}; free_cnt_o = 0.
4. From the exhausted state, free 5, then free 2, then two allocs -> ptrs 5 then 2 (FIFO order, indices wrapped); free_cnt_o back to 0.
5. Alloc ptr 7, free 7, free 7 again -> second free raises err_double_free_o for 1 cycle; free_cnt_o unchanged by it; free of never-allocated ptr 200 -> same error.
6. Simultaneous alloc and free(9) at free_cnt_o = 0 -> WR_ERR_NO_SPACE and free_cnt_o = 1. Then assert rst_n_i low mid-run -> outputs return to reset values asynchronously, and INIT repeats for 256 cycles.

Source files
------------

// File: rtl/sm.sv
// Shared-memory common definitions.
//   SM_PTR_W : buffer pointer width
//   sm_res_t : allocator result record {code, ptr}
package sm;

    localparam int unsigned SM_PTR_W = 8;

    typedef enum logic {
        WR_OK           = 1'b0,
        WR_ERR_NO_SPACE = 1'b1
    } sm_code_e;

    typedef struct packed {
        sm_code_e              code;
        logic [SM_PTR_W-1:0]   ptr;
    } sm_res_t;

endpackage

// File: rtl/sm_ptr_alloc.sv
// Free-pointer allocator for the shared-memory buffer.
// After reset the free list is filled with pointers 0..PTR_CNT-1 (INIT), then
// allocate/free requests are served from a circular FIFO (RUN). A bitmap of
// allocated pointers rejects frees of pointers that are not currently out.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   init_done_o         free list fully populated
//   alloc_req_i         allocate request
//   alloc_ready_o       allocate accepted this cycle
//   res_valid_o         single-cycle result pulse, one cycle after accept
//   res_o               result record {code, ptr}; holds while not valid
//   free_valid_i        free request
//   free_ptr_i          pointer being returned
//   free_ready_o        free accepted this cycle
//   err_double_free_o   pulse: freed pointer was not allocated
//   free_cnt_o          pointers currently in the free list
module sm_ptr_alloc #(
    parameter int unsigned PTR_W   = sm::SM_PTR_W,
    parameter int unsigned PTR_CNT = 2 ** PTR_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic             init_done_o,
    input  logic             alloc_req_i,
    output logic             alloc_ready_o,
    output logic             res_valid_o,
    output sm::sm_res_t      res_o,
    input  logic             free_valid_i,
    input  logic [PTR_W-1:0] free_ptr_i,
    output logic             free_ready_o,
    output logic             err_double_free_o,
    output logic [PTR_W:0]   free_cnt_o
);

    localparam int unsigned CntW = PTR_W + 1;
    localparam int unsigned ResW = sm::SM_PTR_W;

    typedef enum logic {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      mem [PTR_CNT];
    logic [PTR_W-1:0]      rd_idx_q, rd_idx_d;
    logic [PTR_W-1:0]      wr_idx_q, wr_idx_d;
    logic [CntW-1:0]       free_cnt_q, free_cnt_d;
    logic [PTR_CNT-1:0]    bitmap_q, bitmap_d;
    logic                  init_done_q, init_done_d;
    logic                  ready_q, ready_d;
    logic                  res_valid_q, res_valid_d;
    sm::sm_res_t           res_q, res_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    logic [PTR_W-1:0]      mem_wdata;
    logic [PTR_W-1:0]      head_ptr;
    logic                  alloc_acc, free_acc, alloc_ok, free_ok;
    logic                  init_last;

    assign head_ptr  = mem[rd_idx_q];
    assign init_last = (wr_idx_q == {PTR_W{1'b1}});
    // ready_q is only ever high in RUN, so it also gates out INIT requests.
    assign alloc_acc = alloc_req_i & ready_q;
    assign free_acc  = free_valid_i & ready_q;
    // Alloc sees the count before this cycle's free: no bypass.
    assign alloc_ok  = alloc_acc & (free_cnt_q != '0);
    // A pointer allocated in this same cycle is not yet marked, so freeing it fails.
    assign free_ok   = free_acc & bitmap_q[free_ptr_i];

    // State register and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StInit;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            free_cnt_q  <= '0;
            bitmap_q    <= '0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '{code: sm::WR_OK, ptr: '0};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            wr_idx_q    <= wr_idx_d;
            free_cnt_q  <= free_cnt_d;
            bitmap_q    <= bitmap_d;
            init_done_q <= init_done_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            err_q       <= err_d;
        end
    end

    // Free-list storage, not reset: INIT rewrites every entry.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_idx_q] <= mem_wdata;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  if (init_last) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    // Datapath next-state values.
    always_comb begin
        rd_idx_d    = rd_idx_q;
        wr_idx_d    = wr_idx_q;
        free_cnt_d  = free_cnt_q;
        bitmap_d    = bitmap_q;
        init_done_d = init_done_q;
        ready_d     = ready_q;
        res_valid_d = 1'b0;
        res_d       = res_q;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = wr_idx_q;

        if (state_q == StInit) begin
            mem_we     = 1'b1;
            mem_wdata  = wr_idx_q;
            wr_idx_d   = wr_idx_q + 1'b1;
            free_cnt_d = free_cnt_q + CntW'(1);
            if (init_last) begin
                init_done_d = 1'b1;
                ready_d     = 1'b1;
            end
        end else begin
            if (alloc_acc) begin
                res_valid_d = 1'b1;
                if (alloc_ok) begin
                    res_d              = '{code: sm::WR_OK, ptr: ResW'(head_ptr)};
                    rd_idx_d           = rd_idx_q + 1'b1;
                    bitmap_d[head_ptr] = 1'b1;
                end else begin
                    res_d = '{code: sm::WR_ERR_NO_SPACE, ptr: '0};
                end
            end
            if (free_acc) begin
                if (free_ok) begin
                    mem_we               = 1'b1;
                    mem_wdata            = free_ptr_i;
                    wr_idx_d             = wr_idx_q + 1'b1;
                    bitmap_d[free_ptr_i] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            free_cnt_d = free_cnt_q + CntW'(free_ok) - CntW'(alloc_ok);
        end
    end

    // Outputs, all straight from registers.
    always_comb begin
        init_done_o       = init_done_q;
        alloc_ready_o     = ready_q;
        free_ready_o      = ready_q;
        res_valid_o       = res_valid_q;
        res_o             = res_q;
        err_double_free_o = err_q;
        free_cnt_o        = free_cnt_q;
    end

endmodule

// File: tb/tb_sm_ptr_alloc.sv
module tb_sm_ptr_alloc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        alloc_req;
    logic        alloc_ready;
    logic        res_valid;
    sm::sm_res_t res;
    logic        free_valid;
    logic [7:0]  free_ptr;
    logic        free_ready;
    logic        err_df;
    logic [8:0]  free_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       alloc;
        logic       fv;
        logic [7:0] fp;
        logic       valid;
        logic       code;
        logic [7:0] ptr;
        logic       err;
        logic [8:0] cnt;
    } vec_t;

    vec_t seq_a[$];
    vec_t seq_b[$];

    sm_ptr_alloc dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .init_done_o       (init_done),
        .alloc_req_i       (alloc_req),
        .alloc_ready_o     (alloc_ready),
        .res_valid_o       (res_valid),
        .res_o             (res),
        .free_valid_i      (free_valid),
        .free_ptr_i        (free_ptr),
        .free_ready_o      (free_ready),
        .err_double_free_o (err_df),
        .free_cnt_o        (free_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic a, logic fv, logic [7:0] fp, logic valid, logic code,
                                logic [7:0] ptr, logic err, logic [8:0] cnt);
        vec_t v;
        v.alloc = a;     v.fv  = fv;  v.fp  = fp;  v.valid = valid;
        v.code  = code;  v.ptr = ptr; v.err = err; v.cnt   = cnt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(string tag, vec_t v);
        alloc_req  = v.alloc;
        free_valid = v.fv;
        free_ptr   = v.fp;
        step();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_ptr   = '0;
        check({tag, ".valid"}, 32'(res_valid), 32'(v.valid));
        check({tag, ".code"},  32'(res.code),  32'(v.code));
        check({tag, ".ptr"},   32'(res.ptr),   32'(v.ptr));
        check({tag, ".err"},   32'(err_df),    32'(v.err));
        check({tag, ".cnt"},   32'(free_cnt),  32'(v.cnt));
        check({tag, ".rdy"},   32'({init_done, alloc_ready, free_ready}), 32'(3'b111));
    endtask

    task automatic check_reset(string tag);
        check({tag, ".init_done"}, 32'(init_done),   32'(0));
        check({tag, ".ready"},     32'({alloc_ready, free_ready}), 32'(0));
        check({tag, ".valid"},     32'(res_valid),   32'(0));
        check({tag, ".res"},       32'(res),         32'(0));
        check({tag, ".err"},       32'(err_df),      32'(0));
        check({tag, ".cnt"},       32'(free_cnt),    32'(0));
    endtask

    // Waits for init_done with requests held high; none may be accepted.
    task automatic wait_init(string tag);
        int cyc = 0;
        int bad = 0;
        alloc_req  = 1'b1;
        free_valid = 1'b1;
        free_ptr   = 8'd3;
        while (!init_done && cyc < 300) begin
            step();
            cyc++;
            if (!init_done && (alloc_ready || free_ready || res_valid || err_df)) bad++;
        end
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_ptr   = '0;
        check({tag, ".cycles"},    32'(cyc),       32'(256));
        check({tag, ".no_accept"}, 32'(bad),       32'(0));
        check({tag, ".cnt"},       32'(free_cnt),  32'(256));
        check({tag, ".valid"},     32'(res_valid), 32'(0));
        check({tag, ".err"},       32'(err_df),    32'(0));
    endtask

    initial begin
        // After init: never-allocated free, three allocs, hold.
        seq_a.push_back(mk(0, 1, 200, 0, 0, 0, 1, 256));
        seq_a.push_back(mk(1, 0, 0,   1, 0, 0, 0, 255));
        seq_a.push_back(mk(1, 0, 0,   1, 0, 1, 0, 254));
        seq_a.push_back(mk(1, 0, 0,   1, 0, 2, 0, 253));
        seq_a.push_back(mk(0, 0, 0,   0, 0, 2, 0, 253));
        // From exhaustion: no-space, refills, double free, simultaneous cases.
        seq_b.push_back(mk(1, 0, 0,   1, 1, 0,  0, 0));
        seq_b.push_back(mk(0, 1, 5,   0, 1, 0,  0, 1));
        seq_b.push_back(mk(0, 1, 2,   0, 1, 0,  0, 2));
        seq_b.push_back(mk(1, 0, 0,   1, 0, 5,  0, 1));
        seq_b.push_back(mk(1, 0, 0,   1, 0, 2,  0, 0));
        seq_b.push_back(mk(0, 1, 7,   0, 0, 2,  0, 1));
        seq_b.push_back(mk(1, 0, 0,   1, 0, 7,  0, 0));
        seq_b.push_back(mk(0, 1, 7,   0, 0, 7,  0, 1));
        seq_b.push_back(mk(0, 1, 7,   0, 0, 7,  1, 1));
        seq_b.push_back(mk(0, 0, 0,   0, 0, 7,  0, 1));
        seq_b.push_back(mk(1, 0, 0,   1, 0, 7,  0, 0));
        seq_b.push_back(mk(1, 1, 9,   1, 1, 0,  0, 1));
        seq_b.push_back(mk(1, 1, 10,  1, 0, 9,  0, 1));
        seq_b.push_back(mk(1, 1, 10,  1, 0, 10, 1, 0));

        rst_n      = 1'b0;
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_ptr   = '0;
        #3;
        check_reset("reset");
        step();
        rst_n = 1'b1;
        wait_init("init1");

        foreach (seq_a[i]) apply($sformatf("a%0d", i), seq_a[i]);
        for (int i = 3; i < 256; i++) begin
            apply($sformatf("drain%0d", i), mk(1, 0, 0, 1, 0, 8'(i), 0, 9'(255 - i)));
        end
        foreach (seq_b[i]) apply($sformatf("b%0d", i), seq_b[i]);

        // Asynchronous reset mid-run, away from the clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        step();
        step();
        rst_n = 1'b1;
        wait_init("init2");
        apply("post", mk(1, 0, 0, 1, 0, 0, 0, 255));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
